// File: rtl/video_timing_gen_if.sv
// Video output bundle from the timing generator.
// Master drives sync/DE/colour/position; slave observes.
interface video_timing_gen_if;
    logic        video_HS;
    logic        video_VS;
    logic        video_DE;
    logic [23:0] video_RGB;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;

    modport master (
        output video_HS,
        output video_VS,
        output video_DE,
        output video_RGB,
        output pix_x,
        output pix_y,
        output frame_start
    );

    modport slave (
        input video_HS,
        input video_VS,
        input video_DE,
        input video_RGB,
        input pix_x,
        input pix_y,
        input frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator with built-in test patterns.
// All outputs are registered one cycle behind the h/v counters.
module video_timing_gen #(
    parameter int HDISP  = 800,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VDISP  = 480,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic               pixel_clk,
    input  logic               pixel_rst_n,
    input  logic [1:0]         pattern_sel,
    video_timing_gen_if.master vid
);

    localparam int H_TOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int V_TOTAL = VDISP + VFP + VPULSE + VBP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_DISP   = 11'(HDISP);
    localparam logic [10:0] H_SYNC_S = 11'(HDISP + HFP);
    localparam logic [10:0] H_SYNC_E = 11'(HDISP + HFP + HPULSE);
    localparam logic [10:0] BAR_W    = 11'(HDISP / 8);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_DISP   = 10'(VDISP);
    localparam logic [9:0]  V_SYNC_S = 10'(VDISP + VFP);
    localparam logic [9:0]  V_SYNC_E = 10'(VDISP + VFP + VPULSE);

    logic [10:0] r_hcnt;
    logic [9:0]  r_vcnt;
    logic [1:0]  r_pat_q;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_frame0;
    logic        w_de;
    logic        w_hs;
    logic        w_vs;
    logic [1:0]  w_pat;
    logic [2:0]  w_bar_idx;
    logic [23:0] w_rgb;

    assign w_h_wrap = (r_hcnt == H_LAST);
    assign w_v_wrap = (r_vcnt == V_LAST);
    assign w_frame0 = (r_hcnt == 11'd0) && (r_vcnt == 10'd0);

    // Decode the current raster position into sync, enable and colour.
    always_comb begin
        w_de      = (r_hcnt < H_DISP) && (r_vcnt < V_DISP);
        w_hs      = !((r_hcnt >= H_SYNC_S) && (r_hcnt < H_SYNC_E));
        w_vs      = !((r_vcnt >= V_SYNC_S) && (r_vcnt < V_SYNC_E));
        // First pixel of a frame already uses the pattern being latched.
        w_pat     = w_frame0 ? pattern_sel : r_pat_q;
        w_bar_idx = 3'(3'd7 - 3'(r_hcnt / BAR_W));
        w_rgb     = 24'h000000;
        unique case (w_pat)
            2'd0: begin
                if ((r_hcnt[3:0] == 4'd0) || (r_vcnt[3:0] == 4'd0))
                    w_rgb = 24'hFFFFFF;
            end
            2'd1: w_rgb = {{8{w_bar_idx[2]}},
                           {8{w_bar_idx[1]}},
                           {8{w_bar_idx[0]}}};
            2'd2: w_rgb = {r_hcnt[7:0], r_vcnt[7:0], 8'h00};
            2'd3: w_rgb = 24'h000000;
        endcase
        if (!w_de)
            w_rgb = 24'h000000;
    end

    // Horizontal and vertical raster counters.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_hcnt <= 11'd0;
            r_vcnt <= 10'd0;
        end else if (w_h_wrap) begin
            r_hcnt <= 11'd0;
            r_vcnt <= w_v_wrap ? 10'd0 : r_vcnt + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 11'd1;
        end
    end

    // Pattern select only changes on a frame boundary.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n)
            r_pat_q <= 2'd0;
        else if (w_frame0)
            r_pat_q <= pattern_sel;
    end

    // Register every output one cycle behind the counters.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            vid.video_HS    <= 1'b1;
            vid.video_VS    <= 1'b1;
            vid.video_DE    <= 1'b0;
            vid.video_RGB   <= 24'h000000;
            vid.pix_x       <= 11'd0;
            vid.pix_y       <= 10'd0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.video_HS    <= w_hs;
            vid.video_VS    <= w_vs;
            vid.video_DE    <= w_de;
            vid.video_RGB   <= w_rgb;
            vid.pix_x       <= w_de ? r_hcnt : 11'd0;
            vid.pix_y       <= w_de ? r_vcnt : 10'd0;
            vid.frame_start <= w_frame0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a reduced raster.
// Outputs are compared cycle by cycle against a position model.
module tb_video_timing_gen;

    localparam int HDISP  = 32;
    localparam int HFP    = 3;
    localparam int HPULSE = 4;
    localparam int HBP    = 5;
    localparam int VDISP  = 20;
    localparam int VFP    = 2;
    localparam int VPULSE = 3;
    localparam int VBP    = 2;
    localparam int HT     = HDISP + HFP + HPULSE + HBP;
    localparam int VT     = VDISP + VFP + VPULSE + VBP;
    localparam int FRAME  = HT * VT;

    logic       clk;
    logic       rst_n;
    logic [1:0] pattern_sel;

    video_timing_gen_if vif ();

    video_timing_gen #(
        .HDISP (HDISP),
        .HFP   (HFP),
        .HPULSE(HPULSE),
        .HBP   (HBP),
        .VDISP (VDISP),
        .VFP   (VFP),
        .VPULSE(VPULSE),
        .VBP   (VBP)
    ) dut (
        .pixel_clk  (clk),
        .pixel_rst_n(rst_n),
        .pattern_sel(pattern_sel),
        .vid        (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int k;
    int cyc;
    int mpat;
    int fs_last;
    int rand_mode;
    int have_full;
    int de_tot;
    int hs_tot;
    int vs_tot;
    int hs_first;
    int vs_first;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [23:0] exp_rgb(int h, int v, int pat);
        int idx;
        if (h >= HDISP || v >= VDISP)
            return 24'h000000;
        case (pat)
            0: return (h % 16 == 0 || v % 16 == 0) ?
                      24'hFFFFFF : 24'h000000;
            1: begin
                idx = 7 - h / (HDISP / 8);
                return {((idx >> 2) & 1) != 0 ? 8'hFF : 8'h00,
                        ((idx >> 1) & 1) != 0 ? 8'hFF : 8'h00,
                        (idx & 1) != 0 ? 8'hFF : 8'h00};
            end
            2: return {8'(h % 256), 8'(v % 256), 8'h00};
            default: return 24'h000000;
        endcase
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_hs"}, 64'(vif.video_HS), 64'd1);
        chk({tag, "_vs"}, 64'(vif.video_VS), 64'd1);
        chk({tag, "_de"}, 64'(vif.video_DE), 64'd0);
        chk({tag, "_rgb"}, 64'(vif.video_RGB), 64'd0);
        chk({tag, "_x"}, 64'(vif.pix_x), 64'd0);
        chk({tag, "_y"}, 64'(vif.pix_y), 64'd0);
        chk({tag, "_fs"}, 64'(vif.frame_start), 64'd0);
    endtask

    task automatic step();
        int p;
        int h;
        int v;
        logic e_de;
        logic e_hs;
        logic e_vs;
        logic [23:0] e_rgb;
        logic [48:0] got;
        logic [48:0] exp;
        @(posedge clk);
        #1;
        p = k % FRAME;
        h = p % HT;
        v = p / HT;
        if (p == 0) begin
            mpat = int'(pattern_sel);
            if (have_full != 0) begin
                chk("de_per_frame", 64'(de_tot), 64'(HDISP * VDISP));
                chk("hs_per_frame", 64'(hs_tot), 64'(HPULSE * VT));
                chk("vs_per_frame", 64'(vs_tot), 64'(VPULSE * HT));
                chk("hs_offset", 64'(hs_first), 64'(HDISP + HFP));
                chk("vs_offset", 64'(vs_first), 64'((VDISP + VFP) * HT));
            end
            have_full = 1;
            de_tot = 0;
            hs_tot = 0;
            vs_tot = 0;
            hs_first = -1;
            vs_first = -1;
        end
        e_de  = (h < HDISP) && (v < VDISP);
        e_hs  = !(h >= HDISP + HFP && h < HDISP + HFP + HPULSE);
        e_vs  = !(v >= VDISP + VFP && v < VDISP + VFP + VPULSE);
        e_rgb = exp_rgb(h, v, mpat);
        exp = {e_hs, e_vs, e_de, p == 0, e_rgb,
               e_de ? 11'(h) : 11'd0, e_de ? 10'(v) : 10'd0};
        got = {vif.video_HS, vif.video_VS, vif.video_DE,
               vif.frame_start, vif.video_RGB, vif.pix_x, vif.pix_y};
        chk($sformatf("px_%0d_%0d", h, v), 64'(got), 64'(exp));

        if (k == 0) begin
            chk("first_fs", 64'(vif.frame_start), 64'd1);
            chk("first_de", 64'(vif.video_DE), 64'd1);
        end
        if (mpat == 0 && v == 5 && h == 16)
            chk("grid_16_5", 64'(vif.video_RGB), 64'hFFFFFF);
        if (mpat == 0 && v == 5 && h == 17)
            chk("grid_17_5", 64'(vif.video_RGB), 64'h000000);
        if (mpat == 2 && v == 10 && h == 20)
            chk("grad_20_10", 64'(vif.video_RGB), 64'h140A00);
        if (mpat == 1 && v == 0 && h == 0)
            chk("bar_x0", 64'(vif.video_RGB), 64'hFFFFFF);
        if (mpat == 1 && v == 0 && h == 3)
            chk("bar_x3", 64'(vif.video_RGB), 64'hFFFFFF);
        if (mpat == 1 && v == 0 && h == 4)
            chk("bar_x4", 64'(vif.video_RGB), 64'hFFFF00);
        if (mpat == 1 && v == 0 && h == 31)
            chk("bar_x31", 64'(vif.video_RGB), 64'h000000);
        if (mpat == 3 && v == 15 && h == 16)
            chk("black_16_15", 64'(vif.video_RGB), 64'h000000);

        if (vif.video_DE) de_tot++;
        if (!vif.video_HS) begin
            hs_tot++;
            if (hs_first < 0) hs_first = p;
        end
        if (!vif.video_VS) begin
            vs_tot++;
            if (vs_first < 0) vs_first = p;
        end
        if (vif.frame_start) begin
            if (fs_last >= 0)
                chk("fs_period", 64'(cyc - fs_last), 64'(FRAME));
            fs_last = cyc;
        end

        if (rand_mode != 0 && $urandom_range(0, 199) == 0)
            pattern_sel = 2'($urandom);
        k++;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic restart_model();
        k = 0;
        have_full = 0;
        fs_last = -1;
    endtask

    initial begin
        rst_n = 1'b0;
        pattern_sel = 2'd0;
        cyc = 0;
        mpat = 0;
        rand_mode = 0;
        de_tot = 0;
        hs_tot = 0;
        vs_tot = 0;
        hs_first = -1;
        vs_first = -1;
        restart_model();
        #27;
        reset_checks("rst");

        @(negedge clk);
        rst_n = 1'b1;
        run(FRAME);
        pattern_sel = 2'd2;
        run(FRAME);
        pattern_sel = 2'd1;
        run(FRAME);
        pattern_sel = 2'd0;
        run(10 * HT);
        pattern_sel = 2'd3;
        run(FRAME - 10 * HT);
        run(FRAME);

        rand_mode = 1;
        run(2 * FRAME);
        rand_mode = 0;

        run(12 * HT + 7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("async_rst");
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst_hold");
        @(negedge clk);
        pattern_sel = 2'($urandom);
        rst_n = 1'b1;
        restart_model();
        run(FRAME + 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
